// File: rtl/qam_rx_synth_if.sv
// Handshake bundle for qam_rx_synth: R write port, symbol frame input
// and the bottom-up y sample stream.
interface qam_rx_synth_if #(
    parameter int N  = 8,
    parameter int WL = 16
);
    localparam int AW = $clog2(N);

    logic                 r_we;
    logic [AW-1:0]        r_row;
    logic [AW-1:0]        r_col;
    logic signed [WL-1:0] r_data;

    logic                 in_valid;
    logic                 in_ready;
    logic [2*N-1:0]       in_bits;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [WL-1:0] out_y;
    logic [AW-1:0]        out_row;
    logic                 out_last;
    logic                 out_sat;

    modport master (
        output r_we, r_row, r_col, r_data,
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_y,
        input  out_row, out_last, out_sat
    );

    modport slave (
        input  r_we, r_row, r_col, r_data,
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_y,
        output out_row, out_last, out_sat
    );
endinterface

// File: rtl/qam_rx_synth.sv
// Gray 4-PAM mapper and y = R*x synthesiser for upper-triangular R,
// one MAC per cycle, rows emitted bottom-up with saturation.
module qam_rx_synth #(
    parameter int N      = 8,
    parameter int WL     = 16,
    parameter int FWL    = 12,
    parameter int ACC_WL = WL + 4,
    parameter logic signed [WL-1:0] C0 = WL'(3 * (2 ** FWL)),
    parameter logic signed [WL-1:0] C1 = WL'(2 ** FWL),
    parameter logic signed [WL-1:0] C2 = WL'(-3 * (2 ** FWL)),
    parameter logic signed [WL-1:0] C3 = WL'(-(2 ** FWL))
) (
    input logic           clk,
    input logic           rst,
    qam_rx_synth_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic signed [ACC_WL-1:0] AMAX =
        {1'b0, {(ACC_WL-1){1'b1}}};
    localparam logic signed [ACC_WL-1:0] AMIN = ~AMAX;
    localparam logic signed [ACC_WL-1:0] YMAX =
        {{(ACC_WL-WL+1){1'b0}}, {(WL-1){1'b1}}};
    localparam logic signed [ACC_WL-1:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t               state;
    logic signed [WL-1:0] rm [N][N];
    logic [2*N-1:0]       bits;
    logic [AW-1:0]        row;
    logic [AW-1:0]        col;
    logic signed [ACC_WL-1:0] acc;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic signed [WL-1:0] out_y_q;
    logic [AW-1:0]        out_row_q;
    logic                 out_last_q;
    logic                 out_sat_q;

    logic [1:0]               code;
    logic signed [WL-1:0]     coef;
    logic signed [2*WL-1:0]   prod;
    logic signed [ACC_WL-1:0] term;
    logic signed [ACC_WL:0]   sum;
    logic signed [ACC_WL-1:0] acc_nx;
    logic signed [WL-1:0]     y_nx;
    logic                     sat_nx;

    always_comb begin
        code = 2'(bits >> {col, 1'b0});
        unique case (code)
            2'b00: coef = C0;
            2'b01: coef = C1;
            2'b10: coef = C2;
            2'b11: coef = C3;
        endcase
        prod = rm[row][col] * coef;
        term = ACC_WL'(prod >>> FWL);
        sum  = {acc[ACC_WL-1], acc} + {term[ACC_WL-1], term};
        // Clamp instead of wrapping so a full-scale row still saturates
        // in the right direction at the output.
        if (sum[ACC_WL] != sum[ACC_WL-1])
            acc_nx = sum[ACC_WL] ? AMIN : AMAX;
        else
            acc_nx = sum[ACC_WL-1:0];
        sat_nx = 1'b1;
        if (acc_nx > YMAX)
            y_nx = YMAX[WL-1:0];
        else if (acc_nx < YMIN)
            y_nx = YMIN[WL-1:0];
        else begin
            y_nx   = acc_nx[WL-1:0];
            sat_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    rm[i][j] <= '0;
            bits        <= '0;
            row         <= '0;
            col         <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.r_we)
                rm[bus.r_row][bus.r_col] <= bus.r_data;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bits       <= bus.in_bits;
                        row        <= LAST;
                        col        <= LAST;
                        acc        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_nx;
                    if (col == LAST) begin
                        out_y_q     <= y_nx;
                        out_sat_q   <= sat_nx;
                        out_row_q   <= row;
                        out_last_q  <= (row == '0);
                        out_valid_q <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        col <= col + AW'(1);
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (row == '0) begin
                            in_ready_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            row   <= row - AW'(1);
                            col   <= row - AW'(1);
                            acc   <= '0;
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_qam_rx_synth.sv
// Scoreboard bench for qam_rx_synth: expected samples are queued when a
// frame is sent and checked by a monitor as the DUT emits them.
module tb_qam_rx_synth;
    localparam int N      = 8;
    localparam int WL     = 16;
    localparam int FWL    = 12;
    localparam int ACC_WL = WL + 4;
    localparam int YMAX   = (1 << (WL - 1)) - 1;
    localparam int YMIN   = -(1 << (WL - 1));

    typedef struct {
        logic signed [WL-1:0] y;
        logic [2:0]           row;
        logic                 last;
        logic                 sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    qam_rx_synth_if #(.N(N), .WL(WL)) bus();

    qam_rx_synth #(.N(N), .WL(WL), .FWL(FWL), .ACC_WL(ACC_WL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   asserts = 0;
    int   fails   = 0;
    int   rm [N][N];

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            asserts++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: got row %0d y %0d, want nothing",
                         bus.out_row, bus.out_y);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_y !== mon_e.y || bus.out_row !== mon_e.row ||
                    bus.out_last !== mon_e.last ||
                    bus.out_sat !== mon_e.sat) begin
                    fails++;
                    $display("FAIL sample: got row %0d y %0d last %0b sat %0b, want row %0d y %0d last %0b sat %0b",
                             bus.out_row, bus.out_y, bus.out_last,
                             bus.out_sat, mon_e.row, mon_e.y,
                             mon_e.last, mon_e.sat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_r(input int r, input int c, input int d);
        bus.r_we   = 1'b1;
        bus.r_row  = 3'(r);
        bus.r_col  = 3'(c);
        bus.r_data = WL'(d);
        tick();
        bus.r_we = 1'b0;
        rm[r][c] = d;
    endtask

    task automatic load_r(input int diag, input int off);
        for (int r = 0; r < N; r++)
            for (int c = r; c < N; c++)
                write_r(r, c, (r == c) ? diag : off);
    endtask

    task automatic push_const(input int y, input int r, input bit sat);
        exp_t e;
        e.y    = WL'(y);
        e.row  = 3'(r);
        e.last = (r == 0);
        e.sat  = sat;
        sb.push_back(e);
    endtask

    function automatic void push_model(input logic [2*N-1:0] b);
        longint amax = (longint'(1) <<< (ACC_WL - 1)) - 1;
        longint amin = -(longint'(1) <<< (ACC_WL - 1));
        for (int i = N - 1; i >= 0; i--) begin
            longint acc = 0;
            longint p;
            int     lv;
            exp_t   e;
            for (int c = i; c < N; c++) begin
                case (b[2*c +: 2])
                    2'b00:   lv = 3;
                    2'b01:   lv = 1;
                    2'b10:   lv = -3;
                    default: lv = -1;
                endcase
                p = (longint'(rm[i][c]) * (longint'(lv) <<< FWL)) >>> FWL;
                acc += p;
                if (acc > amax) acc = amax;
                if (acc < amin) acc = amin;
            end
            e.sat = 1'b1;
            if (acc > YMAX) e.y = WL'(YMAX);
            else if (acc < YMIN) e.y = WL'(YMIN);
            else begin
                e.y   = WL'(acc);
                e.sat = 1'b0;
            end
            e.row  = 3'(i);
            e.last = (i == 0);
            sb.push_back(e);
        end
    endfunction

    task automatic send(input logic [2*N-1:0] b);
        bit got = 0;
        bus.in_bits  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        asserts++;
        if (!got) begin
            fails++;
            $display("FAIL accept: in_ready got 0, want 1 within 200 cycles");
        end
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.in_ready) begin
                done = 1;
                break;
            end
        end
        asserts++;
        if (!done) begin
            fails++;
            $display("FAIL drain: %0d samples outstanding, want 0",
                     sb.size());
        end
        tick();
    endtask

    task automatic wait_row(input int r);
        bit seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_row == 3'(r)) begin
                seen = 1;
                break;
            end
        end
        asserts++;
        if (!seen) begin
            fails++;
            $display("FAIL wait_row: row %0d got none, want valid", r);
        end
    endtask

    task automatic push_ramp();
        for (int i = N - 1; i >= 0; i--)
            push_const((3 * (N - i)) << (FWL - 3), i, 0);
    endtask

    task automatic test_reset();
        bus.r_we      = 1'b0;
        bus.r_row     = '0;
        bus.r_col     = '0;
        bus.r_data    = '0;
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.out_ready = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                rm[r][c] = 0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        asserts += 3;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_hs: got valid %0b ready %0b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        if (bus.out_y !== '0 || bus.out_row !== '0) begin
            fails++;
            $display("FAIL reset_y: got y %0d row %0d, want 0 0",
                     bus.out_y, bus.out_row);
        end
        if (bus.out_last !== 1'b0 || bus.out_sat !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got last %0b sat %0b, want 0 0",
                     bus.out_last, bus.out_sat);
        end
        tick();
    endtask

    task automatic test_identity();
        int first = -1;
        int ret   = -1;
        load_r(1 << FWL, 0);
        for (int i = N - 1; i >= 0; i--)
            push_const(-3 << FWL, i, 0);
        send({N{2'b10}});
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.out_valid && first < 0) first = n;
            if (bus.in_ready) begin
                ret = n;
                break;
            end
        end
        asserts += 2;
        if (first != 2) begin
            fails++;
            $display("FAIL latency: got %0d, want 2", first);
        end
        if (ret != 45) begin
            fails++;
            $display("FAIL frame_len: in_ready back at %0d, want 45", ret);
        end
        wait_done();
    endtask

    task automatic test_ramp();
        load_r(1 << (FWL - 3), 1 << (FWL - 3));
        push_ramp();
        send({N{2'b00}});
        wait_done();
    endtask

    task automatic test_saturate();
        load_r(YMAX, YMAX);
        for (int i = N - 1; i >= 0; i--)
            push_const(YMAX, i, 1);
        send({N{2'b00}});
        wait_done();
        for (int i = N - 1; i >= 0; i--)
            push_const(YMIN, i, 1);
        send({N{2'b10}});
        wait_done();
    endtask

    task automatic test_stall();
        logic signed [WL-1:0] y0;
        logic [2:0]           r0;
        load_r(1 << (FWL - 3), 1 << (FWL - 3));
        push_ramp();
        send({N{2'b00}});
        wait_row(6);
        tick();
        bus.out_ready = 1'b0;
        wait_row(5);
        y0 = bus.out_y;
        r0 = bus.out_row;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            asserts++;
            if (!bus.out_valid || bus.out_y !== y0 ||
                bus.out_row !== r0 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall: got v %0b y %0d row %0d rdy %0b, want 1 %0d %0d 0",
                         bus.out_valid, bus.out_y, bus.out_row,
                         bus.in_ready, y0, r0);
            end
        end
        tick();
        bus.out_ready = 1'b1;
        wait_done();
    endtask

    task automatic test_abort();
        load_r(1 << (FWL - 3), 1 << (FWL - 3));
        push_ramp();
        send({N{2'b00}});
        wait_row(4);
        tick();
        tick();
        rst = 1'b0;
        #1;
        asserts++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort: got valid %0b ready %0b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        sb.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                rm[r][c] = 0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = N - 1; i >= 0; i--)
            push_const(0, i, 0);
        send(16'h1b6c);
        wait_done();
    endtask

    task automatic test_we_ignored();
        logic [2*N-1:0] b;
        load_r(1 << (FWL - 3), 1 << (FWL - 3));
        b = 16'(($urandom & 16'haaaa) | 16'h0100);
        push_model(b);
        send(b);
        bus.r_row  = 3'(7);
        bus.r_col  = 3'(7);
        bus.r_data = '0;
        bus.r_we   = 1'b1;
        repeat (3) tick();
        bus.r_we = 1'b0;
        wait_done();
        push_model(b);
        send(b);
        wait_done();
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] b;
        for (int r = 0; r < N; r++)
            for (int c = r; c < N; c++)
                write_r(r, c, int'($signed(16'($urandom_range(0, 65535)))));
        for (int f = 0; f < 3; f++) begin
            b = 16'($urandom);
            push_model(b);
            send(b);
        end
        wait_done();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ramp();
        test_saturate();
        test_stall();
        test_abort();
        test_we_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end
endmodule
